// File: rtl/trs_ps2_pkg.sv
// trs_ps2_pkg: shared definitions for the PS/2 device-side transmitter.
//   - ps2_state_e : transmitter FSM states
//   - FRAME_BITS  : bits per PS/2 frame (start + 8 data + parity + stop)
//   - CLK_DIV_DEFAULT : default Clk cycles per PS/2 clock half-period
//   - build_frame : assemble the LSB-first shift word for one scancode byte
package trs_ps2_pkg;

    localparam int unsigned FRAME_BITS      = 11;
    localparam int unsigned CLK_DIV_DEFAULT = 64;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } ps2_state_e;

    // Bit 0 goes out first: start(0), data LSB..MSB, odd parity, stop(1).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

endpackage

// File: rtl/trs_ps2_tx_if.sv
// trs_ps2_tx_if: host-side write port of the PS/2 transmitter.
//   Data_In : scancode byte to send        (master -> slave)
//   Wr      : one-cycle write strobe        (master -> slave)
//   Full    : no space for a write this cycle (slave -> master)
//   Busy    : frame in progress or bytes queued (slave -> master)
//   Ovf     : sticky dropped-write flag     (slave -> master)
interface trs_ps2_tx_if;

    logic [7:0] Data_In;
    logic       Wr;
    logic       Full;
    logic       Busy;
    logic       Ovf;

    modport master (
        output Data_In,
        output Wr,
        input  Full,
        input  Busy,
        input  Ovf
    );

    modport slave (
        input  Data_In,
        input  Wr,
        output Full,
        output Busy,
        output Ovf
    );

endinterface

// File: rtl/trs_ps2_fifo.sv
// trs_ps2_fifo: scancode queue in front of the PS/2 transmitter.
// Build option: PS2_TX_FIFO_EN defined -> DEPTH-entry circular FIFO;
// undefined -> single holding register (DEPTH is then unused by the datapath).
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   push, din  : write request and byte (ignored while full)
//   pop        : consume the head entry (ignored while empty)
//   dout       : head entry
//   empty      : nothing queued
//   full       : registered; no space for a push this cycle
module trs_ps2_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("trs_ps2_fifo: DEPTH must be a power of 2 in 2..16");
    end

`ifdef PS2_TX_FIFO_EN

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q;
    logic            do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & (count_q != '0);

    // Simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CntW'(DEPTH));
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = full_q;

`else

    logic [7:0] hold_q;
    logic       valid_q;

    // Stays full from an accepted write until the transmitter pops it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else if (push && !valid_q) begin
            hold_q  <= din;
            valid_q <= 1'b1;
        end else if (pop && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign dout  = hold_q;
    assign empty = ~valid_q;
    assign full  = valid_q;

`endif

endmodule

// File: rtl/trs_ps2_tx.sv
// trs_ps2_tx: PS/2 device-side transmitter (keyboard -> host direction).
// Sends each queued scancode as an 11-bit frame; PS2_Data only changes while
// PS2_Clk is high so the host samples on the falling edge.
// Build option: PS2_TX_FIFO_EN selects a FIFO_DEPTH-entry queue; otherwise a
// single holding register buffers one byte.
// Ports:
//   Clk      : clock, all state on rising edge
//   Rst_n    : asynchronous active-low reset; aborts any frame
//   host     : trs_ps2_tx_if.slave (Data_In, Wr, Full, Busy, Ovf)
//   PS2_Clk  : PS/2 clock, idle high
//   PS2_Data : PS/2 data, idle high
module trs_ps2_tx
    import trs_ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    trs_ps2_tx_if.slave   host,
    output logic          PS2_Clk,
    output logic          PS2_Data
);

    if (CLK_DIV < 2 || CLK_DIV > 1023) begin : g_bad_clk_div
        $error("trs_ps2_tx: CLK_DIV must be in 2..1023");
    end

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] HalfMax = CntW'(CLK_DIV - 1);
    // LOAD already drives the start bit with PS2_Clk high, so the first
    // high phase in SHIFT is one cycle short.
    localparam logic [CntW-1:0] FirstMax = CntW'(CLK_DIV - 2);
    localparam logic [3:0]      LastBit  = 4'(FRAME_BITS - 1);

    ps2_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [3:0]            bit_cnt_q;
    logic [CntW-1:0]       cnt_q;
    logic                  phase_q;   // SHIFT: low half; GAP: second half
    logic                  ovf_q;
    logic                  half_done;

    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;

    trs_ps2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (host.Wr),
        .pop   (fifo_pop),
        .din   (host.Data_In),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign half_done = (cnt_q == '0);
    assign fifo_pop  = (state_q == StLoad);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!fifo_empty) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (half_done && phase_q && bit_cnt_q == LastBit) state_d = StGap;
            StGap:   if (half_done && phase_q) state_d = fifo_empty ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
    end

    // Frame datapath: half-period counter reloads on every phase change.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shift_q   <= '1;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    shift_q   <= build_frame(fifo_dout);
                    cnt_q     <= FirstMax;
                    phase_q   <= 1'b0;
                    bit_cnt_q <= '0;
                end
                StShift: begin
                    if (!half_done) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        cnt_q   <= HalfMax;
                        phase_q <= ~phase_q;
                        // End of a low half: advance to the next bit.
                        if (phase_q) begin
                            shift_q   <= {1'b1, shift_q[FRAME_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                StGap: begin
                    if (!half_done) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        cnt_q   <= HalfMax;
                        phase_q <= ~phase_q;
                    end
                end
                default: begin
                    cnt_q     <= '0;
                    phase_q   <= 1'b0;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

    // Ovf is sticky until reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                   ovf_q <= 1'b0;
        else if (host.Wr && fifo_full) ovf_q <= 1'b1;
    end

    // Output decode; reset forces IDLE so both lines go high immediately.
    always_comb begin
        PS2_Clk  = 1'b1;
        PS2_Data = 1'b1;
        case (state_q)
            StLoad: PS2_Data = 1'b0;
            StShift: begin
                PS2_Clk  = ~phase_q;
                PS2_Data = shift_q[0];
            end
            default: begin
                PS2_Clk  = 1'b1;
                PS2_Data = 1'b1;
            end
        endcase
    end

    assign host.Full = fifo_full;
    assign host.Busy = (state_q != StIdle) | ~fifo_empty;
    assign host.Ovf  = ovf_q;

endmodule
